fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that produces the instruction word the control unit decodes. It owns the PC, issues read requests to the instruction memory/cache (imemREN/imemaddr, completed by ihit), and holds each fetched word plus its PC+4 in a one-entry output register with a valid/ready handshake toward decode. It accepts branch/jump redirects, squashes the held instruction on redirect, and stops fetching once a HALT opcode has been fetched.

## Interface
Parameters:
- PC_INIT, 32'h00000000, PC loaded on reset; low 2 bits must be 0.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction read complete; imemload valid this cycle for the current imemaddr.
- imemload  in  32  instruction word from memory.
- imemREN  out  1  read request.
- imemaddr  out  32  request address; always equals the PC register.
- instr_ready  in  1  decode accepts instr this cycle.
- instr  out  32  held instruction (word_t).
- instr_valid  out  1  instr holds an unconsumed instruction.
- npc  out  32  PC+4 of the held instruction.
- redirect_en  in  1  branch/jump/jumpFlush redirect.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- halted  out  1  fetch is stopped on HALT.

## Operation
- States: IDLE, REQ, HOLD, HALTED. Reset state is IDLE.
- Reset values: pc = PC_INIT, instr = 0, npc = 0, instr_valid = 0, imemREN = 0, halted = 0.
- slot_free = !instr_valid || instr_ready.
- IDLE: imemREN = 0. Moves to REQ on the next edge.
- REQ: imemREN = slot_free.
  - Capture when ihit && slot_free: instr <= imemload, npc <= pc+4, instr_valid <= 1, pc <= pc+4.
  - If the captured opcode is HALT (6'b111111), go to HALTED. Otherwise stay in REQ.
  - If instr_valid && !instr_ready, go to HOLD.
  - If instr_ready and no capture, instr_valid <= 0.
- HOLD: imemREN = 0. Returns to REQ on the edge where instr_ready is 1, and instr_valid <= 0 on that edge.
- HALTED: imemREN = 0, halted = 1, pc frozen. The HALT word stays valid until consumed; then instr_valid <= 0.
- Redirect has priority over every other event, in any state including HALTED:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - instr_valid <= 0.
  - A same-cycle ihit is dropped.
  - Next state is REQ, and halted clears.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000, with no flag.
- imemaddr changes only on capture or redirect, so the address is stable while waiting for ihit.

## Timing
- imemREN is combinational from state and slot_free. imemaddr is registered.
- Fetch latency: ihit in cycle n produces instr/instr_valid/npc visible in cycle n+1.
- Back-to-back: with single-cycle ihit and instr_ready held at 1, throughput is one instruction per cycle.
- Redirect in cycle n: imemaddr = target in cycle n+1 and instr_valid = 0 in cycle n+1.
- Asserting RST mid-operation forces all reset values immediately, without waiting for CLK.
- The first request is issued in the second cycle after RST deasserts (IDLE lasts one cycle).

## Configuration
- FETCH_PERF_CNT_EN defined: adds two 32-bit output ports.
  - fetch_count increments on each capture.
  - wait_count increments each cycle with imemREN && !ihit.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- FETCH_PERF_CNT_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- cpu_types_pkg: word_t, opcode_t (including HALT), a new fetch_state_t enum (IDLE, REQ, HOLD, HALTED), and a WORD_INC constant = 4.
- fetch_if interface in include/, with modports fetch and tb.
- One sub-module: fetch_pc_reg, holding the PC register with reset, redirect load, increment, and enable.

## Test plan
- Reset with PC_INIT = 32'h00000100, then ihit = 1 every cycle and instr_ready = 1 -> imemaddr 0x100, 0x104, 0x108 on consecutive cycles; instr_valid = 1 from the first capture; npc = 0x104 for the first word.
- ihit delayed 3 cycles -> imemaddr stable at 0x100 for 4 cycles; a single capture; wait_count = 3 when FETCH_PERF_CNT_EN is defined.
- instr_ready = 0 for 2 cycles after a capture -> HOLD, imemREN = 0, instr unchanged; resumes at pc+4 after ready.
- redirect_en with redirect_pc = 32'h00000203 in the same cycle as ihit -> word dropped, instr_valid = 0, next imemaddr = 0x200.
- Fetch 32'hFFFFFFFF at pc 0x10 -> halted = 1, imemREN = 0 thereafter; a later redirect to 0x40 clears halted and fetching resumes at 0x40.
- pc = 32'hFFFFFFFC with ihit -> npc = 0 and next imemaddr = 0. Assert RST mid-wait -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: instruction word, opcodes, fetch FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDIU = 6'b001001,
        LW    = 6'b100011,
        SW    = 6'b101011,
        HALT  = 6'b111111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        HALTED
    } fetch_state_t;

    localparam word_t WORD_INC   = 32'd4;
    localparam word_t ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic is_halt(input logic [5:0] op);
        return op == HALT;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch stage signals; modport fetch is the unit's view, tb the environment's.
interface fetch_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;
    logic  instr_ready;
    word_t instr;
    logic  instr_valid;
    word_t npc;
    logic  redirect_en;
    word_t redirect_pc;
    logic  halted;

    modport fetch (
        input  ihit, imemload, instr_ready, redirect_en, redirect_pc,
        output imemREN, imemaddr, instr, instr_valid, npc, halted
    );

    modport tb (
        output ihit, imemload, instr_ready, redirect_en, redirect_pc,
        input  imemREN, imemaddr, instr, instr_valid, npc, halted
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset value, word-aligned redirect load, and +4 increment.
module fetch_pc_reg
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load_en,
    input  word_t load_pc,
    input  logic  inc_en,
    output word_t pc
);

    // A load (redirect) wins over an increment taken in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= PC_INIT;
        end else if (load_en) begin
            pc <= load_pc & ALIGN_MASK;
        end else if (inc_en) begin
            pc <= pc + WORD_INC;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with one-entry output register toward decode.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  word_t       imemload,
    output logic        imemREN,
    output word_t       imemaddr,
    input  logic        instr_ready,
    output word_t       instr,
    output logic        instr_valid,
    output word_t       npc,
    input  logic        redirect_en,
    input  word_t       redirect_pc,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] wait_count
`endif
);

    fetch_state_t state;
    fetch_state_t next_state;
    word_t        pc;
    logic         slot_free;
    logic         capture;

    assign slot_free = !instr_valid || instr_ready;

    fetch_pc_reg #(
        .PC_INIT (PC_INIT)
    ) u_pc_reg (
        .clk     (CLK),
        .rst     (RST),
        .load_en (redirect_en),
        .load_pc (redirect_pc),
        .inc_en  (capture),
        .pc      (pc)
    );

    assign imemaddr = pc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Redirect overrides every state, including HALTED.
    always_comb begin
        next_state = state;
        if (redirect_en) begin
            next_state = REQ;
        end else begin
            case (state)
                IDLE:   next_state = REQ;
                REQ: begin
                    if (capture) begin
                        next_state = is_halt(imemload[31:26]) ? HALTED : REQ;
                    end else if (instr_valid && !instr_ready) begin
                        next_state = HOLD;
                    end
                end
                HOLD:   next_state = instr_ready ? REQ : HOLD;
                HALTED: next_state = HALTED;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        imemREN = 1'b0;
        halted  = 1'b0;
        capture = 1'b0;
        case (state)
            REQ: begin
                imemREN = slot_free;
                capture = ihit && slot_free && !redirect_en;
            end
            HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr       <= '0;
            npc         <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_en) begin
            instr_valid <= 1'b0;
        end else if (capture) begin
            instr       <= imemload;
            npc         <= pc + WORD_INC;
            instr_valid <= 1'b1;
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_count <= '0;
            wait_count  <= '0;
        end else begin
            if (capture && fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (imemREN && !ihit && wait_count != 32'hFFFF_FFFF) begin
                wait_count <= wait_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with PC_INIT = 0x100.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    typedef struct {
        logic  ihit;
        word_t load;
        logic  ready;
        logic  redir;
        word_t rpc;
        logic  exp_ren;
        word_t exp_addr;
        logic  exp_valid;
        word_t exp_instr;
        word_t exp_npc;
        logic  exp_halted;
    } vec_t;

    localparam word_t W0 = 32'h2401_0001;
    localparam word_t W1 = 32'h2402_0002;
    localparam word_t W2 = 32'h2403_0003;
    localparam word_t W3 = 32'h2404_0004;
    localparam word_t W4 = 32'h2405_0005;
    localparam word_t W5 = 32'h2406_0006;
    localparam word_t W6 = 32'h2407_0006;
    localparam word_t W7 = 32'h2407_0007;
    localparam word_t W8 = 32'h2408_0008;
    localparam word_t HW = 32'hFFFF_FFFF;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   passes = 0;
    vec_t vecs[24];

    fetch_if fif();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] wait_count;
`endif

    fetch_unit #(
        .PC_INIT (32'h0000_0100)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (fif.ihit),
        .imemload    (fif.imemload),
        .imemREN     (fif.imemREN),
        .imemaddr    (fif.imemaddr),
        .instr_ready (fif.instr_ready),
        .instr       (fif.instr),
        .instr_valid (fif.instr_valid),
        .npc         (fif.npc),
        .redirect_en (fif.redirect_en),
        .redirect_pc (fif.redirect_pc),
        .halted      (fif.halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .wait_count  (wait_count)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic ihit, input word_t load, input logic ready,
                                input logic redir, input word_t rpc, input logic ren,
                                input word_t addr, input logic valid, input word_t ins,
                                input word_t np, input logic hlt);
        vec_t v;
        v.ihit = ihit; v.load = load; v.ready = ready; v.redir = redir; v.rpc = rpc;
        v.exp_ren = ren; v.exp_addr = addr; v.exp_valid = valid;
        v.exp_instr = ins; v.exp_npc = np; v.exp_halted = hlt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        fif.ihit        = v.ihit;
        fif.imemload    = v.load;
        fif.instr_ready = v.ready;
        fif.redirect_en = v.redir;
        fif.redirect_pc = v.rpc;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        checks++;
        if (fif.imemREN !== v.exp_ren || fif.imemaddr !== v.exp_addr ||
            fif.instr_valid !== v.exp_valid || fif.instr !== v.exp_instr ||
            fif.npc !== v.exp_npc || fif.halted !== v.exp_halted) begin
            $display("[TB] FAIL %s: got ren=%b addr=%h valid=%b instr=%h npc=%h halted=%b, expected ren=%b addr=%h valid=%b instr=%h npc=%h halted=%b",
                     name, fif.imemREN, fif.imemaddr, fif.instr_valid, fif.instr, fif.npc, fif.halted,
                     v.exp_ren, v.exp_addr, v.exp_valid, v.exp_instr, v.exp_npc, v.exp_halted);
        end else begin
            passes++;
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            passes++;
        end
    endtask

    initial begin
        //               ihit load ready redir rpc            ren addr           valid instr npc            halted
        vecs[0]  = mk(0, 0,  1, 0, 0,             0, 32'h100,       0, 0,  0,             0);
        vecs[1]  = mk(1, W0, 1, 0, 0,             1, 32'h100,       0, 0,  0,             0);
        vecs[2]  = mk(1, W1, 1, 0, 0,             1, 32'h104,       1, W0, 32'h104,       0);
        vecs[3]  = mk(1, W2, 1, 0, 0,             1, 32'h108,       1, W1, 32'h108,       0);
        vecs[4]  = mk(0, 0,  1, 0, 0,             1, 32'h10C,       1, W2, 32'h10C,       0);
        vecs[5]  = mk(0, 0,  1, 0, 0,             1, 32'h10C,       0, W2, 32'h10C,       0);
        vecs[6]  = mk(0, 0,  1, 0, 0,             1, 32'h10C,       0, W2, 32'h10C,       0);
        vecs[7]  = mk(1, W3, 1, 0, 0,             1, 32'h10C,       0, W2, 32'h10C,       0);
        vecs[8]  = mk(0, 0,  0, 0, 0,             0, 32'h110,       1, W3, 32'h110,       0);
        vecs[9]  = mk(0, 0,  0, 0, 0,             0, 32'h110,       1, W3, 32'h110,       0);
        vecs[10] = mk(0, 0,  1, 0, 0,             0, 32'h110,       1, W3, 32'h110,       0);
        vecs[11] = mk(1, W4, 1, 0, 0,             1, 32'h110,       0, W3, 32'h110,       0);
        vecs[12] = mk(1, W5, 1, 1, 32'h203,       1, 32'h114,       1, W4, 32'h114,       0);
        vecs[13] = mk(0, 0,  1, 1, 32'h10,        1, 32'h200,       0, W4, 32'h114,       0);
        vecs[14] = mk(1, HW, 1, 0, 0,             1, 32'h10,        0, W4, 32'h114,       0);
        vecs[15] = mk(1, W6, 0, 0, 0,             0, 32'h14,        1, HW, 32'h14,        1);
        vecs[16] = mk(0, 0,  1, 0, 0,             0, 32'h14,        1, HW, 32'h14,        1);
        vecs[17] = mk(0, 0,  1, 0, 0,             0, 32'h14,        0, HW, 32'h14,        1);
        vecs[18] = mk(0, 0,  1, 1, 32'h40,        0, 32'h14,        0, HW, 32'h14,        1);
        vecs[19] = mk(1, W7, 1, 0, 0,             1, 32'h40,        0, HW, 32'h14,        0);
        vecs[20] = mk(0, 0,  1, 1, 32'hFFFF_FFFE, 1, 32'h44,        1, W7, 32'h44,        0);
        vecs[21] = mk(1, W8, 1, 0, 0,             1, 32'hFFFF_FFFC, 0, W7, 32'h44,        0);
        vecs[22] = mk(0, 0,  1, 0, 0,             1, 32'h0,         1, W8, 32'h0,         0);
        vecs[23] = mk(0, 0,  1, 0, 0,             1, 32'h0,         0, W8, 32'h0,         0);

        applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge CLK);
        #1;
        checkOutput(mk(0, 0, 1, 0, 0, 0, 32'h100, 0, 0, 0, 0), "reset_state");
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge CLK);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], $sformatf("vec%0d", i));
`ifdef FETCH_PERF_CNT_EN
            if (i == 8) begin
                checkValue("fetch_count_after_wait", fetch_count, 32'd4);
                checkValue("wait_count_after_wait", wait_count, 32'd3);
            end
            if (i == 23) begin
                checkValue("fetch_count_end", fetch_count, 32'd8);
                checkValue("wait_count_end", wait_count, 32'd6);
            end
`endif
        end

        // Reset asserted between clock edges while a request is outstanding.
        #1;
        RST = 1'b1;
        #1;
        checkOutput(mk(0, 0, 1, 0, 0, 0, 32'h100, 0, 0, 0, 0), "async_reset_mid_wait");
`ifdef FETCH_PERF_CNT_EN
        checkValue("fetch_count_reset", fetch_count, 32'd0);
        checkValue("wait_count_reset", wait_count, 32'd0);
`endif

        @(negedge CLK);
        RST = 1'b0;
        applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput(mk(0, 0, 1, 0, 0, 0, 32'h100, 0, 0, 0, 0), "post_reset_idle");
        @(negedge CLK);
        applyStimulus(mk(1, W0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput(mk(1, W0, 1, 0, 0, 1, 32'h100, 0, 0, 0, 0), "post_reset_first_req");
        @(negedge CLK);
        applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput(mk(0, 0, 1, 0, 0, 1, 32'h104, 1, W0, 32'h104, 0), "post_reset_capture");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
